cpu_ctrl_seq: RTL and testbench

Hardwired control sequencer that drives the CPU control bus: ALU_OPCODE, MID, SID, AMID, PC_INR, MID_EN, SID_EN.
- Runs a two-byte fetch into IR0/IR1, decodes IR0, then runs a two-cycle execute transfer.
- Replaces bench-driven control words; sits between the instruction registers and the bus/register-file enables inside CPU.

---
 rtl/cpu_ctrl_seq_if.sv | 21 ++
 rtl/cpu_ctrl_seq.sv | 172 +++++++++++++++++
 tb/tb_cpu_ctrl_seq.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_seq_if.sv
// cpu_ctrl_seq_if: sequencer bus bundle, instruction bytes in, control word and status out
interface cpu_ctrl_seq_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic [7:0]       ir0;
    logic [7:0]       ir1;
    logic [32:0]      control_bus;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;
    logic [2:0]       t_state;
    modport master (
        input  run, ir0, ir1,
        output control_bus, halted, illegal, instr_count, t_state
    );
    modport slave (
        output run, ir0, ir1,
        input  control_bus, halted, illegal, instr_count, t_state
    );
endinterface

// File: rtl/cpu_ctrl_seq.sv
// cpu_ctrl_seq: hardwired fetch/decode/execute control sequencer; CTRL_ILLEGAL_TRAP_EN traps opcodes 0x6..0xF
module cpu_ctrl_seq #(
    parameter int ALU_W  = 5,
    parameter int ID_W   = 5,
    parameter int AMID_W = 2,
    parameter int CNT_W  = 16
) (
    input  logic           clk,
    input  logic           reset,
    cpu_ctrl_seq_if.master bus
);
    localparam int FW = ALU_W + 2 * ID_W + AMID_W + 3;
    typedef enum logic [3:0] {
        IDLE = 4'd0, T0 = 4'd1, T1 = 4'd2, T2 = 4'd3, T3 = 4'd4,
        T4 = 4'd5, E0 = 4'd6, E1 = 4'd7, HALT = 4'd8
    } state_t;
    localparam logic [3:0] OP_HLT = 4'h1;
    localparam logic [3:0] OP_LDI = 4'h2;
    localparam logic [3:0] OP_ALU = 4'h3;
    localparam logic [3:0] OP_LDM = 4'h4;
    localparam logic [3:0] OP_STM = 4'h5;
    localparam logic [ID_W-1:0] ID_IR0 = ID_W'(0);
    localparam logic [ID_W-1:0] ID_IR1 = ID_W'(1);
    localparam logic [ID_W-1:0] ID_A   = ID_W'(2);
    localparam logic [ID_W-1:0] ID_MEM = ID_W'(4);
    localparam logic [ID_W-1:0] ID_ALU = ID_W'(5);
    localparam logic [AMID_W-1:0] AM_PC  = AMID_W'(0);
    localparam logic [AMID_W-1:0] AM_IR1 = AMID_W'(1);

    state_t           state_q, state_d;
    logic [3:0]       opcode_q, opcode_d;
    logic [3:0]       aluf_q, aluf_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0]       op_in;
    logic             retire;
    logic [ALU_W-1:0] alu_op;
    logic [ID_W-1:0]  mid, sid;
    logic [AMID_W-1:0] amid;
    logic             pc_inr, mid_en, sid_en;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic             illegal_q, illegal_d;
`endif

    assign op_in = bus.ir0[7:4];

    // Next state, opcode latch at T4, and retire bookkeeping
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        aluf_d   = aluf_q;
        count_d  = count_q;
        retire   = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        case (state_q)
            IDLE: state_d = bus.run ? T0 : IDLE;
            T0:   state_d = T1;
            T1:   state_d = T2;
            T2:   state_d = T3;
            T3:   state_d = T4;
            T4: begin
                opcode_d = op_in;
                aluf_d   = bus.ir0[3:0];
                if (op_in == OP_HLT) begin
                    state_d = HALT;
                    count_d = count_q + CNT_W'(1);
                end else if (op_in >= OP_LDI && op_in <= OP_STM) begin
                    state_d = E0;
`ifdef CTRL_ILLEGAL_TRAP_EN
                end else if (op_in > OP_STM) begin
                    state_d   = HALT;
                    illegal_d = 1'b1;
`endif
                end else begin
                    retire = 1'b1;
                end
            end
            E0:   state_d = E1;
            E1:   retire = 1'b1;
            default: state_d = state_q;
        endcase
        if (retire) begin
            count_d = count_q + CNT_W'(1);
            state_d = bus.run ? T0 : IDLE;
        end
    end

    // Falling-edge update so the decoded outputs are settled at the datapath's rising edge
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            opcode_q <= 4'h0;
            aluf_q   <= 4'h0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            aluf_q   <= aluf_d;
            count_q  <= count_d;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    // Sticky trap flag, cleared only by reset
    always_ff @(negedge clk or posedge reset) begin
        if (reset) illegal_q <= 1'b0;
        else       illegal_q <= illegal_d;
    end
    assign bus.illegal = illegal_q;
`else
    assign bus.illegal = 1'b0;
`endif

    // Moore decode of state and latched opcode onto the control-bus fields
    always_comb begin
        alu_op = '0;
        mid    = '0;
        sid    = '0;
        amid   = '0;
        pc_inr = 1'b0;
        mid_en = 1'b0;
        sid_en = 1'b0;
        case (state_q)
            T0, T2: begin
                amid   = AM_PC;
                mid    = ID_MEM;
                mid_en = 1'b1;
            end
            T1, T3: begin
                mid    = ID_MEM;
                mid_en = 1'b1;
                sid    = (state_q == T1) ? ID_IR0 : ID_IR1;
                sid_en = 1'b1;
                pc_inr = 1'b1;
            end
            E0, E1: begin
                mid_en = 1'b1;
                sid_en = (state_q == E1);
                case (opcode_q)
                    OP_LDI: begin
                        mid = ID_IR1;
                        sid = ID_A;
                    end
                    OP_ALU: begin
                        mid    = ID_ALU;
                        sid    = ID_A;
                        alu_op = ALU_W'(aluf_q);
                    end
                    OP_LDM: begin
                        amid = AM_IR1;
                        mid  = ID_MEM;
                        sid  = ID_A;
                    end
                    OP_STM: begin
                        amid = AM_IR1;
                        mid  = ID_A;
                        sid  = ID_MEM;
                    end
                    default: mid_en = 1'b0;
                endcase
            end
            default: mid_en = 1'b0;
        endcase
    end

    // Upper control-bus bits beyond the packed fields are reserved and read as zero
    assign bus.control_bus = {{(33 - FW){1'b0}}, alu_op, mid, sid, amid, pc_inr, mid_en, sid_en};
    assign bus.halted      = (state_q == HALT);
    assign bus.instr_count = count_q;
    assign bus.t_state     = (state_q == HALT) ? 3'd0 : state_q[2:0];
endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// tb_cpu_ctrl_seq: directed self-checking bench for cpu_ctrl_seq
module tb_cpu_ctrl_seq;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic reset_w = 1'b1;
    int n_pass = 0;
    int n_chk = 0;
    logic [15:0] exp_cnt = 16'd0;

    always #5 clk = ~clk;

    cpu_ctrl_seq_if bus ();
    cpu_ctrl_seq_if #(.CNT_W(4)) bus_w ();

    cpu_ctrl_seq dut (.clk(clk), .reset(reset), .bus(bus.master));
    cpu_ctrl_seq #(.CNT_W(4)) dut_w (.clk(clk), .reset(reset_w), .bus(bus_w.master));

    function automatic logic [32:0] cb(int alu, int mid, int sid, int amid, int pc, int me, int se);
        return {13'b0, 5'(alu), 5'(mid), 5'(sid), 2'(amid), 1'(pc), 1'(me), 1'(se)};
    endfunction

    function automatic logic [32:0] fetch_cb(int k);
        case (k)
            0: return cb(0, 4, 0, 0, 0, 1, 0);
            1: return cb(0, 4, 0, 0, 1, 1, 1);
            2: return cb(0, 4, 0, 0, 0, 1, 0);
            3: return cb(0, 4, 1, 0, 1, 1, 1);
            default: return 33'd0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.run = 1'b0; bus.ir0 = 8'h00; bus.ir1 = 8'h00;
        bus_w.run = 1'b0; bus_w.ir0 = 8'h00; bus_w.ir1 = 8'h00;
        #22;
        n_chk++; if (bus.control_bus !== 33'd0) $display("FAIL reset_cb: got %h want 0", bus.control_bus); else n_pass++;
        n_chk++; if (bus.halted !== 1'b0 || bus.illegal !== 1'b0) $display("FAIL reset_flags: got %b%b want 00", bus.halted, bus.illegal); else n_pass++;
        n_chk++; if (bus.instr_count !== 16'd0) $display("FAIL reset_cnt: got %h want 0", bus.instr_count); else n_pass++;
        n_chk++; if (bus.t_state !== 3'd0) $display("FAIL reset_t: got %0d want 0", bus.t_state); else n_pass++;
        step();
        reset = 1'b0;
        step();
        step();
        n_chk++; if (bus.t_state !== 3'd0 || bus.control_bus !== 33'd0) $display("FAIL idle_hold: got t=%0d cb=%h want t=0 cb=0", bus.t_state, bus.control_bus); else n_pass++;
    endtask

    task automatic test_nop();
        bus.run = 1'b1;
        bus.ir0 = 8'h00;
        step();
        for (int k = 0; k < 5; k++) begin
            n_chk++; if (bus.control_bus !== fetch_cb(k) || bus.t_state !== 3'(k + 1)) $display("FAIL nop_fetch k=%0d: got cb=%h t=%0d want cb=%h t=%0d", k, bus.control_bus, bus.t_state, fetch_cb(k), k + 1); else n_pass++;
            step();
        end
        exp_cnt = 16'd1;
        n_chk++; if (bus.instr_count !== exp_cnt || bus.t_state !== 3'd1) $display("FAIL nop_retire: got cnt=%h t=%0d want cnt=%h t=1", bus.instr_count, bus.t_state, exp_cnt); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] ops [4] = '{8'h2A, 8'h37, 8'h4C, 8'h50};
        logic [32:0] e0 [4];
        e0[0] = cb(0, 1, 2, 0, 0, 1, 0);
        e0[1] = cb(7, 5, 2, 0, 0, 1, 0);
        e0[2] = cb(0, 4, 2, 1, 0, 1, 0);
        e0[3] = cb(0, 2, 4, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            bus.ir0 = ops[i];
            bus.ir1 = 8'h5A;
            for (int k = 0; k < 5; k++) begin
                n_chk++; if (bus.control_bus !== fetch_cb(k)) $display("FAIL xfer_fetch op=%h k=%0d: got %h want %h", ops[i], k, bus.control_bus, fetch_cb(k)); else n_pass++;
                step();
            end
            n_chk++; if (bus.control_bus !== e0[i] || bus.t_state !== 3'd6) $display("FAIL xfer_e0 op=%h: got cb=%h t=%0d want cb=%h t=6", ops[i], bus.control_bus, bus.t_state, e0[i]); else n_pass++;
            step();
            n_chk++; if (bus.control_bus !== (e0[i] | 33'd1) || bus.t_state !== 3'd7) $display("FAIL xfer_e1 op=%h: got cb=%h t=%0d want cb=%h t=7", ops[i], bus.control_bus, bus.t_state, e0[i] | 33'd1); else n_pass++;
            step();
            exp_cnt++;
            n_chk++; if (bus.instr_count !== exp_cnt || bus.t_state !== 3'd1) $display("FAIL xfer_retire op=%h: got cnt=%h t=%0d want cnt=%h t=1", ops[i], bus.instr_count, bus.t_state, exp_cnt); else n_pass++;
        end
    endtask

    task automatic test_run_drop();
        bus.ir0 = 8'h2A;
        repeat (5) step();
        n_chk++; if (bus.t_state !== 3'd6) $display("FAIL drop_e0: got t=%0d want 6", bus.t_state); else n_pass++;
        bus.run = 1'b0;
        step();
        n_chk++; if (bus.t_state !== 3'd7 || bus.control_bus !== cb(0, 1, 2, 0, 0, 1, 1)) $display("FAIL drop_e1: got t=%0d cb=%h want t=7 cb=%h", bus.t_state, bus.control_bus, cb(0, 1, 2, 0, 0, 1, 1)); else n_pass++;
        step();
        exp_cnt++;
        n_chk++; if (bus.t_state !== 3'd0 || bus.control_bus !== 33'd0 || bus.instr_count !== exp_cnt) $display("FAIL drop_idle: got t=%0d cb=%h cnt=%h want t=0 cb=0 cnt=%h", bus.t_state, bus.control_bus, bus.instr_count, exp_cnt); else n_pass++;
        step();
        n_chk++; if (bus.t_state !== 3'd0) $display("FAIL drop_stay: got t=%0d want 0", bus.t_state); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bus.run = 1'b1;
        bus.ir0 = 8'h00;
        repeat (3) step();
        n_chk++; if (bus.t_state !== 3'd3) $display("FAIL rmid_t2: got t=%0d want 3", bus.t_state); else n_pass++;
        reset = 1'b1;
        #1;
        exp_cnt = 16'd0;
        n_chk++; if (bus.control_bus !== 33'd0 || bus.t_state !== 3'd0 || bus.instr_count !== exp_cnt) $display("FAIL rmid_async: got cb=%h t=%0d cnt=%h want 0 0 0", bus.control_bus, bus.t_state, bus.instr_count); else n_pass++;
        step();
        reset = 1'b0;
    endtask

    task automatic test_halt();
        bus.run = 1'b1;
        bus.ir0 = 8'h10;
        step();
        for (int k = 0; k < 5; k++) begin
            n_chk++; if (bus.control_bus !== fetch_cb(k)) $display("FAIL hlt_fetch k=%0d: got %h want %h", k, bus.control_bus, fetch_cb(k)); else n_pass++;
            step();
        end
        n_chk++; if (bus.halted !== 1'b1 || bus.control_bus !== 33'd0 || bus.t_state !== 3'd0 || bus.instr_count !== 16'd1) $display("FAIL hlt_enter: got h=%b cb=%h t=%0d cnt=%h want h=1 cb=0 t=0 cnt=1", bus.halted, bus.control_bus, bus.t_state, bus.instr_count); else n_pass++;
        for (int k = 0; k < 20; k++) begin
            step();
            n_chk++; if (bus.halted !== 1'b1 || bus.control_bus !== 33'd0) $display("FAIL hlt_hold c=%0d: got h=%b cb=%h want h=1 cb=0", k, bus.halted, bus.control_bus); else n_pass++;
        end
        reset = 1'b1;
        #1;
        n_chk++; if (bus.halted !== 1'b0 || bus.instr_count !== 16'd0) $display("FAIL hlt_reset: got h=%b cnt=%h want h=0 cnt=0", bus.halted, bus.instr_count); else n_pass++;
        step();
        reset = 1'b0;
    endtask

    task automatic test_illegal();
        bus.run = 1'b1;
        bus.ir0 = 8'h9F;
        step();
        repeat (5) step();
`ifdef CTRL_ILLEGAL_TRAP_EN
        n_chk++; if (bus.illegal !== 1'b1 || bus.halted !== 1'b1 || bus.instr_count !== 16'd0 || bus.control_bus !== 33'd0) $display("FAIL ill_trap: got i=%b h=%b cnt=%h cb=%h want i=1 h=1 cnt=0 cb=0", bus.illegal, bus.halted, bus.instr_count, bus.control_bus); else n_pass++;
`else
        n_chk++; if (bus.illegal !== 1'b0 || bus.halted !== 1'b0 || bus.instr_count !== 16'd1 || bus.t_state !== 3'd1) $display("FAIL ill_nop: got i=%b h=%b cnt=%h t=%0d want i=0 h=0 cnt=1 t=1", bus.illegal, bus.halted, bus.instr_count, bus.t_state); else n_pass++;
`endif
        bus.run = 1'b0;
        reset = 1'b1;
        #1;
        n_chk++; if (bus.illegal !== 1'b0) $display("FAIL ill_reset: got %b want 0", bus.illegal); else n_pass++;
        step();
        reset = 1'b0;
    endtask

    task automatic test_wrap();
        reset_w = 1'b0;
        bus_w.run = 1'b1;
        bus_w.ir0 = 8'h00;
        repeat (76) step();
        n_chk++; if (bus_w.instr_count !== 4'hF) $display("FAIL wrap_max: got %h want f", bus_w.instr_count); else n_pass++;
        repeat (5) step();
        n_chk++; if (bus_w.instr_count !== 4'h0 || bus_w.t_state !== 3'd1) $display("FAIL wrap_zero: got cnt=%h t=%0d want cnt=0 t=1", bus_w.instr_count, bus_w.t_state); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_nop();
        test_back_to_back();
        test_run_drop();
        test_reset_mid();
        test_halt();
        test_illegal();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
